// File: rtl/reg_xfer_ctrl_pkg.sv
// Shared types for the register-bus transfer sequencer: op codes, FSM states,
// default geometry and small op classification helpers.
package reg_xfer_ctrl_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int NUM_REGS_DEF = 8;
  localparam int SEL_W_DEF    = 3;

  typedef enum logic [1:0] {
    OP_MOV   = 2'b00,
    OP_LDI   = 2'b01,
    OP_RDOUT = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPT,
    ST_WRITE,
    ST_DONE
  } state_e;

  function automatic logic op_uses_src(input op_e op);
    return (op == OP_MOV) || (op == OP_RDOUT);
  endfunction

  function automatic logic op_uses_dst(input op_e op);
    return (op == OP_MOV) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/reg_xfer_ctrl_if.sv
// Request side plus register-bus side of the transfer sequencer, bundled.
// The slave modport is the sequencer's view; master is the requester/register side.
interface reg_xfer_ctrl_if
  import reg_xfer_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int SEL_W    = SEL_W_DEF
);
  logic                start;
  logic [1:0]          op;
  logic [SEL_W-1:0]    src_sel;
  logic [SEL_W-1:0]    dst_sel;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W-1:0]   reg_rdata;
  logic [NUM_REGS-1:0] rs;
  logic                rd;
  logic                wr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   result;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, op, src_sel, dst_sel, imm, reg_rdata,
    input  rs, rd, wr, wdata, result, busy, done, err
  );

  modport slave (
    input  start, op, src_sel, dst_sel, imm, reg_rdata,
    output rs, rd, wr, wdata, result, busy, done, err
  );
endinterface

// File: rtl/reg_xfer_ctrl_reg_sel_decode.sv
// Register index to one-hot select decoder with an out-of-range flag.
module reg_sel_decode #(
  parameter int SEL_W    = 3,
  parameter int NUM_REGS = 8
) (
  input  logic [SEL_W-1:0]    sel_i,
  output logic [NUM_REGS-1:0] onehot_o,
  output logic                oor_o
);
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
    assign onehot_o[gi] = (sel_i == SEL_W'(gi));
  end

  // Indices past NUM_REGS decode to all-zero; the flag lets callers reject them.
  assign oor_o = (32'(sel_i) >= 32'(NUM_REGS));
endmodule

// File: rtl/reg_xfer_ctrl.sv
// Register-bus sequencer: one MOV / LDI / RDOUT transfer per request, driving
// select, read/write strobes and the write-data bus of the register file.
module reg_xfer_ctrl
  import reg_xfer_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int SEL_W    = SEL_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  reg_xfer_ctrl_if.slave bus
);
  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [NUM_REGS-1:0] src_oh_q, src_oh_d;
  logic [NUM_REGS-1:0] dst_oh_q, dst_oh_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                err_q, err_d;

  logic [NUM_REGS-1:0] src_oh, dst_oh;
  logic                src_oor, dst_oor;
  logic                req_bad;
  op_e                 req_op;
  logic [NUM_REGS-1:0] rs_sel;
  logic                rd_stb, wr_stb;

  reg_sel_decode #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_src_dec (
    .sel_i    (bus.src_sel),
    .onehot_o (src_oh),
    .oor_o    (src_oor)
  );

  reg_sel_decode #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_dst_dec (
    .sel_i    (bus.dst_sel),
    .onehot_o (dst_oh),
    .oor_o    (dst_oor)
  );

  // Only indices the op actually uses can make a request illegal.
  assign req_op  = op_e'(bus.op);
  assign req_bad = (req_op == OP_RSVD)
                || (op_uses_src(req_op) && src_oor)
                || (op_uses_dst(req_op) && dst_oor);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MOV;
      src_oh_q <= '0;
      dst_oh_q <= '0;
      data_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src_oh_q <= src_oh_d;
      dst_oh_q <= dst_oh_d;
      data_q   <= data_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src_oh_d = src_oh_q;
    dst_oh_d = dst_oh_q;
    data_d   = data_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    err_d    = err_q;
    rs_sel   = '0;
    rd_stb   = 1'b0;
    wr_stb   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d     = req_op;
          src_oh_d = src_oh;
          dst_oh_d = dst_oh;
          data_d   = bus.imm;
          err_d    = req_bad;
          if (req_bad) begin
            state_d = ST_DONE;
          end else if (req_op == OP_LDI) begin
            wdata_d = bus.imm;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        rs_sel  = src_oh_q;
        rd_stb  = 1'b1;
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        data_d = bus.reg_rdata;
        if (op_q == OP_MOV) begin
          wdata_d = bus.reg_rdata;
          state_d = ST_WRITE;
        end else begin
          result_d = bus.reg_rdata;
          state_d  = ST_DONE;
        end
      end
      ST_WRITE: begin
        rs_sel  = dst_oh_q;
        wr_stb  = 1'b1;
        state_d = ST_DONE;
        // Moved value becomes visible on result together with done.
        if (op_q == OP_MOV) begin
          result_d = data_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.rs     = rs_sel;
  assign bus.rd     = rd_stb;
  assign bus.wr     = wr_stb;
  assign bus.wdata  = wdata_q;
  assign bus.result = result_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.err    = (state_q == ST_DONE) && err_q;
endmodule
